// File: rtl/noc_line_fill_if.sv
// noc_line_fill_if: bundles the fill-request/status, line-buffer write and NoC read signals.
// Ports: master = line-fill engine (drives status, line write, NoC request);
//        slave  = miss handler / line buffer / NoC side (drives fill request and NoC response).
interface noc_line_fill_if #(
  parameter int DATA_WIDTH_MSB = 15,
  parameter int ADDR_WIDTH_MSB = 10,
  parameter int LINE_WORDS     = 4
);
  localparam int IDX_W = $clog2(LINE_WORDS);

  // miss handler side
  logic                    fill_req;
  logic [ADDR_WIDTH_MSB:0] fill_addr;
  logic                    fill_busy;
  logic                    fill_done;
  logic                    fill_err;
  // cache line buffer write port
  logic                    line_we;
  logic [IDX_W-1:0]        line_idx;
  logic [DATA_WIDTH_MSB:0] line_data;
  // NoC read port
  logic                    rd_valid;
  logic [ADDR_WIDTH_MSB:0] rd_addr;
  logic                    rd_ready;
  logic [DATA_WIDTH_MSB:0] rd_data;

  modport master (
    input  fill_req, fill_addr, rd_ready, rd_data,
    output fill_busy, fill_done, fill_err, line_we, line_idx, line_data, rd_valid, rd_addr
  );

  modport slave (
    output fill_req, fill_addr, rd_ready, rd_data,
    input  fill_busy, fill_done, fill_err, line_we, line_idx, line_data, rd_valid, rd_addr
  );
endinterface

// File: rtl/noc_line_fill.sv
// noc_line_fill: burst read initiator; fetches one cache line word-by-word over a NoC read port.
// Ports: clk, rst_n (async active-low); bus = noc_line_fill_if.master (fill req/status,
//        line-buffer write strobe/index/data, NoC rd_valid/rd_addr/rd_ready/rd_data).
// Latency: rd_valid one cycle after fill_req; line_we one cycle after each rd_ready, followed by
//          a one-cycle GAP; fill_done coincides with the last line_we (2*LINE_WORDS zero-wait).
// Backpressure: rd_valid/rd_addr held until rd_ready; TIMEOUT cycles without it -> fill_err.
// Build option: define NOC_FILL_CRITICAL_WORD_EN for critical-word-first wrap order
//               (otherwise every line is fetched from offset 0).
module noc_line_fill #(
  parameter int DATA_WIDTH_MSB = 15,
  parameter int ADDR_WIDTH_MSB = 10,
  parameter int LINE_WORDS     = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  noc_line_fill_if.master bus
);
  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int ADDR_W = ADDR_WIDTH_MSB + 1;
  localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(LINE_WORDS - 1);
  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_DONE, S_ERR} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH_MSB:0] base_q;
  logic [IDX_W-1:0]        idx_q;
  // Words already accepted; sized to the line so it covers every legal LINE_WORDS.
  logic [IDX_W-1:0]        cnt_q;
  logic [7:0]              wait_q;

  logic                    rd_valid_q;
  logic [ADDR_WIDTH_MSB:0] rd_addr_q;
  logic                    fill_busy_q;
  logic                    fill_done_q;
  logic                    fill_err_q;
  logic                    line_we_q;
  logic [IDX_W-1:0]        line_idx_q;
  logic [DATA_WIDTH_MSB:0] line_data_q;

  logic [ADDR_WIDTH_MSB:0] base_d;
  logic [IDX_W-1:0]        start_idx_d;
  logic [IDX_W-1:0]        idx_inc_d;

  assign base_d    = bus.fill_addr & ~ADDR_W'(LINE_WORDS - 1);
  // Wraps inside the line because LINE_WORDS is a power of two.
  assign idx_inc_d = idx_q + IDX_W'(1);

`ifdef NOC_FILL_CRITICAL_WORD_EN
  assign start_idx_d = bus.fill_addr[IDX_W-1:0];
`else
  assign start_idx_d = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
      fill_err_q  <= 1'b0;
      line_we_q   <= 1'b0;
      line_idx_q  <= '0;
      line_data_q <= '0;
    end else begin
      line_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.fill_req) begin
            state_q     <= S_REQ;
            base_q      <= base_d;
            idx_q       <= start_idx_d;
            cnt_q       <= '0;
            wait_q      <= '0;
            rd_valid_q  <= 1'b1;
            rd_addr_q   <= base_d | ADDR_W'(start_idx_d);
            fill_busy_q <= 1'b1;
          end
        end
        S_REQ: begin
          // rd_ready is checked first so a grant in the expiry cycle still lands the word.
          if (bus.rd_ready) begin
            line_we_q   <= 1'b1;
            line_idx_q  <= idx_q;
            line_data_q <= bus.rd_data;
            idx_q       <= idx_inc_d;
            cnt_q       <= cnt_q + IDX_W'(1);
            wait_q      <= '0;
            rd_valid_q  <= 1'b0;
            if (cnt_q == LAST_CNT) begin
              state_q     <= S_DONE;
              fill_done_q <= 1'b1;
              rd_addr_q   <= '0;
            end else begin
              // Next address is set up during the GAP so it is stable when rd_valid returns.
              state_q   <= S_GAP;
              rd_addr_q <= base_q | ADDR_W'(idx_inc_d);
            end
          end else if (wait_q == WAIT_LAST) begin
            state_q    <= S_ERR;
            fill_err_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_GAP: begin
          // rd_ready arriving here is ignored: no request is outstanding.
          rd_valid_q <= 1'b1;
          state_q    <= S_REQ;
        end
        S_DONE: begin
          fill_done_q <= 1'b0;
          fill_busy_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        S_ERR: begin
          fill_err_q  <= 1'b0;
          fill_busy_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.fill_busy = fill_busy_q;
  assign bus.fill_done = fill_done_q;
  assign bus.fill_err  = fill_err_q;
  assign bus.line_we   = line_we_q;
  assign bus.line_idx  = line_idx_q;
  assign bus.line_data = line_data_q;
endmodule

// File: tb/tb_noc_line_fill.sv
// tb_noc_line_fill: self-checking bench for noc_line_fill (LINE_WORDS=4, TIMEOUT=8).
// Ports: none; drives the DUT through a noc_line_fill_if instance and models the NoC.
module tb_noc_line_fill;
  localparam int DW   = 15;
  localparam int AW   = 10;
  localparam int LW   = 4;
  localparam int TO   = 8;
  localparam int IW   = 2;
  localparam int MAXC = 128;
  localparam int NV   = 8;

  typedef logic [AW:0]   addr_t;
  typedef logic [DW:0]   data_t;
  typedef logic [IW-1:0] idx_t;

  typedef struct {
    addr_t addr;
    int    d0, d1, d2, d3;   // wait cycles before rd_ready per word (>= TO: never)
    int    req_again;        // cycle of a spurious fill_req while busy (-1: none)
    int    exp_end;          // cycle of fill_done / fill_err
    int    exp_we;           // number of line_we pulses
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_line_fill_if #(.DATA_WIDTH_MSB(DW), .ADDR_WIDTH_MSB(AW), .LINE_WORDS(LW)) bus ();

  noc_line_fill #(
    .DATA_WIDTH_MSB(DW), .ADDR_WIDTH_MSB(AW), .LINE_WORDS(LW), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int    dly [LW];
  vec_t  tbl [NV];
  int    model_end;
  bit    model_err;
  logic  exp_valid [MAXC];
  addr_t exp_addr  [MAXC];
  logic  exp_ready [MAXC];
  logic  exp_we    [MAXC];
  idx_t  exp_idx   [MAXC];
  data_t exp_dat   [MAXC];
  logic  exp_done  [MAXC];
  logic  exp_err   [MAXC];
  logic  exp_busy  [MAXC];

  function automatic data_t noc_data(input addr_t a);
    return {a[4:0], a} ^ 16'hA5C3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.rd_valid, bus.fill_busy, bus.fill_done, bus.fill_err, bus.line_we}), 64'd0);
    check({tag, "_addr"}, 64'(bus.rd_addr), 64'd0);
    check({tag, "_line"}, 64'({bus.line_idx, bus.line_data}), 64'd0);
  endtask

  // Cycle-indexed expectation of one fill, cycle 0 = the fill_req cycle.
  task automatic build_model(input addr_t addr);
    int    t, r;
    int    start;
    addr_t base, a;
    for (int c = 0; c < MAXC; c++) begin
      exp_valid[c] = 1'b0; exp_addr[c] = '0; exp_ready[c] = 1'b0; exp_we[c] = 1'b0;
      exp_idx[c] = '0; exp_dat[c] = '0; exp_done[c] = 1'b0; exp_err[c] = 1'b0; exp_busy[c] = 1'b0;
    end
`ifdef NOC_FILL_CRITICAL_WORD_EN
    start = int'(addr) % LW;
`else
    start = 0;
`endif
    base      = addr_t'(int'(addr) - (int'(addr) % LW));
    t         = 1;
    model_err = 1'b0;
    model_end = 0;
    for (int k = 0; k < LW; k++) begin
      a = addr_t'(int'(base) + ((start + k) % LW));
      if (dly[k] >= TO) begin
        for (int c = t; c < t + TO; c++) begin exp_valid[c] = 1'b1; exp_addr[c] = a; end
        model_end = t + TO;
        model_err = 1'b1;
        break;
      end
      r = t + dly[k];
      for (int c = t; c <= r; c++) begin exp_valid[c] = 1'b1; exp_addr[c] = a; end
      exp_ready[r]  = 1'b1;
      exp_we[r+1]   = 1'b1;
      exp_idx[r+1]  = idx_t'(int'(a) % LW);
      exp_dat[r+1]  = noc_data(a);
      model_end     = r + 1;
      t             = r + 2;
    end
    if (model_err) exp_err[model_end] = 1'b1;
    else           exp_done[model_end] = 1'b1;
    for (int c = 1; c <= model_end; c++) exp_busy[c] = 1'b1;
  endtask

  // Entered and left at posedge+1. abort_at >= 0 pulls rst_n low mid-cycle at that cycle.
  task automatic run_fill(input addr_t addr, input int req_again, input int abort_at,
                          output int obs_end, output int obs_we);
    int ra;
    build_model(addr);
    ra      = (req_again > model_end) ? model_end : req_again;
    obs_end = -1;
    obs_we  = 0;
    for (int c = 0; c <= model_end + 2; c++) begin
      if (c == abort_at) begin
        bus.fill_req = 1'b0;
        bus.rd_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_idle_zero("async_rst");
        repeat (3) begin
          @(negedge clk);
          check_idle_zero("held_rst");
          if (bus.fill_done || bus.fill_err) obs_end = c;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
      bus.fill_req  = (c == 0) || (c == ra);
      bus.fill_addr = (c == 0) ? addr : addr_t'($urandom);
      // Spurious grants outside requests must be ignored by the DUT.
      bus.rd_ready  = exp_ready[c] ? 1'b1 : (exp_valid[c] ? 1'b0 : 1'($urandom));
      bus.rd_data   = exp_ready[c] ? noc_data(bus.rd_addr) : data_t'($urandom);
      @(negedge clk);
      check($sformatf("rd_valid@%0d", c), 64'(bus.rd_valid), 64'(exp_valid[c]));
      if (exp_valid[c]) check($sformatf("rd_addr@%0d", c), 64'(bus.rd_addr), 64'(exp_addr[c]));
      check($sformatf("line_we@%0d", c), 64'(bus.line_we), 64'(exp_we[c]));
      if (exp_we[c]) begin
        check($sformatf("line_idx@%0d", c), 64'(bus.line_idx), 64'(exp_idx[c]));
        check($sformatf("line_data@%0d", c), 64'(bus.line_data), 64'(exp_dat[c]));
      end
      check($sformatf("fill_done@%0d", c), 64'(bus.fill_done), 64'(exp_done[c]));
      check($sformatf("fill_err@%0d", c), 64'(bus.fill_err), 64'(exp_err[c]));
      check($sformatf("fill_busy@%0d", c), 64'(bus.fill_busy), 64'(exp_busy[c]));
      if (bus.line_we) obs_we++;
      if (bus.fill_done || bus.fill_err) obs_end = c;
      @(posedge clk);
      #1;
    end
    bus.fill_req = 1'b0;
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual still running, required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int oe, ow;
    tbl[0] = '{11'h012,   0,   0, 0, 0, -1,  8, 4};  // zero-wait
    tbl[1] = '{11'h012,   5,   5, 5, 5, -1, 28, 4};  // 5-cycle NoC wait per word
    tbl[2] = '{11'h3FF,   0,   1, 2, 3, -1, 14, 4};  // mixed waits, top of address space
    tbl[3] = '{11'h045,   7,   0, 7, 0, -1, 22, 4};  // grant on the last legal wait cycle
    tbl[4] = '{11'h100,   0, 100, 0, 0, -1, 11, 1};  // timeout on word 1
    tbl[5] = '{11'h013,   2,   0, 0, 0,  2, 10, 4};  // fill_req while busy is dropped
    tbl[6] = '{11'h002, 100,   0, 0, 0, -1,  9, 0};  // timeout on word 0
    tbl[7] = '{11'h7FC,   0,   0, 0, 8, -1, 15, 3};  // timeout on the last word

    bus.fill_req  = 1'b0;
    bus.fill_addr = '0;
    bus.rd_ready  = 1'b0;
    bus.rd_data   = '0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      dly[0] = tbl[i].d0; dly[1] = tbl[i].d1; dly[2] = tbl[i].d2; dly[3] = tbl[i].d3;
      run_fill(tbl[i].addr, tbl[i].req_again, -1, oe, ow);
      check($sformatf("vec%0d_end_cycle", i), 64'(oe), 64'(tbl[i].exp_end));
      check($sformatf("vec%0d_we_count", i), 64'(ow), 64'(tbl[i].exp_we));
    end

    // Reset while word 2 is being requested, then a clean fill.
    for (int k = 0; k < LW; k++) dly[k] = 0;
    run_fill(11'h0A6, -1, 5, oe, ow);
    check("abort_no_done_err", 64'(oe), 64'(-1));
    check("abort_we_count", 64'(ow), 64'(2));
    run_fill(11'h0A6, -1, -1, oe, ow);
    check("after_reset_end_cycle", 64'(oe), 64'(8));

    for (int n = 0; n < 25; n++) begin
      addr_t a;
      int    ra;
      a = addr_t'($urandom);
      for (int k = 0; k < LW; k++)
        dly[k] = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 7));
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1;
      run_fill(a, ra, -1, oe, ow);
      check($sformatf("rand%0d_end_cycle", n), 64'(oe), 64'(model_end));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
